// File: rtl/acc_sequencer.sv
// Accumulator command sequencer: accepts an ALU command, issues it to an external
// ALU CmdRepeat+1 times, folding each result into the accumulator.
package acc_sequencer_pkg;
  localparam logic [3:0] kADD = 4'd0;
  localparam logic [3:0] kSUB = 4'd1;
  localparam logic [3:0] kAND = 4'd2;
  localparam logic [3:0] kXOR = 4'd3;
  localparam logic [3:0] kRXR = 4'd4;
  localparam logic [3:0] kLSL = 4'd5;
  localparam logic [3:0] kCMP = 4'd6;
  localparam logic [3:0] kCLR = 4'd7;
  // Outside the defined opcodes: the ALU passes the accumulator through.
  localparam logic [3:0] kNOP = 4'hF;
endpackage

module acc_sequencer
  import acc_sequencer_pkg::*;
#(
  parameter int RPT_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [3:0]       CmdOp,
  input  logic [7:0]       CmdOperand,
  input  logic [RPT_W-1:0] CmdRepeat,
  input  logic             Abort,
  output logic [7:0]       AluInputA,
  output logic [7:0]       AluAccIn,
  output logic [3:0]       AluOp,
  input  logic [7:0]       AluOut,
  input  logic             AluZero,
  output logic [7:0]       Acc,
  output logic             ZeroFlag,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [7:0]       operand_q;
  logic [RPT_W-1:0] remaining_q;
  logic [7:0]       acc_q;
  logic             zero_q;
  logic             accept;
  logic             commit;

  // Handshake: a command transfers on a rising edge where CmdValid && CmdReady;
  // CmdReady is high only in IDLE, so CmdValid is ignored while a command runs.
  always_comb begin
    state_d   = state_q;
    CmdReady  = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    AluOp     = kNOP;
    AluInputA = 8'd0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        CmdReady = 1'b1;
        Busy     = 1'b0;
        accept   = CmdValid;
        if (CmdValid) state_d = EXEC;
      end
      EXEC: begin
        AluOp     = op_q;
        AluInputA = operand_q;
        // Abort wins over the pass, including the final one.
        if (Abort) begin
          state_d = IDLE;
        end else begin
          commit = 1'b1;
          if (remaining_q == '0) state_d = DONE;
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q        <= kNOP;
      operand_q   <= 8'd0;
      remaining_q <= '0;
      acc_q       <= 8'd0;
      zero_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= CmdOp;
        operand_q   <= CmdOperand;
        remaining_q <= CmdRepeat;
      end
      if (commit) begin
        acc_q  <= AluOut;
        zero_q <= AluZero;
        if (remaining_q != '0) remaining_q <= remaining_q - RPT_W'(1);
      end
    end
  end

  assign AluAccIn  = acc_q;
  assign Acc       = acc_q;
  assign ZeroFlag  = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a command-level model.
module tb_acc_sequencer;
  import acc_sequencer_pkg::*;

  localparam int RPT_W = 3;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             CmdValid = 1'b0;
  logic             CmdReady;
  logic [3:0]       CmdOp = 4'd0;
  logic [7:0]       CmdOperand = 8'd0;
  logic [RPT_W-1:0] CmdRepeat = '0;
  logic             Abort = 1'b0;
  logic [7:0]       AluInputA, AluAccIn, AluOut, Acc;
  logic [3:0]       AluOp;
  logic             AluZero, ZeroFlag, Busy, Done;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  acc_sequencer #(.RPT_W(RPT_W)) dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdOperand(CmdOperand), .CmdRepeat(CmdRepeat), .Abort(Abort),
    .AluInputA(AluInputA), .AluAccIn(AluAccIn), .AluOp(AluOp),
    .AluOut(AluOut), .AluZero(AluZero), .Acc(Acc), .ZeroFlag(ZeroFlag),
    .Busy(Busy), .Done(Done), .dbg_state(dbg_state)
  );

  // ---------------- ALU environment: {zero, result} ----------------
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] acc);
    logic [7:0] r;
    logic       z;
    r = acc;
    case (op)
      kADD: r = acc + a;
      kSUB: r = acc - a;
      kAND: r = acc & a;
      kXOR: r = acc ^ a;
      kRXR: r = {acc[0], acc[7:1]};
      kLSL: r = {acc[6:0], 1'b0};
      kCMP: r = acc;
      kCLR: r = 8'd0;
      default: r = acc;
    endcase
    z = (op == kCMP) ? (acc == a) : (r == 8'd0);
    return {z, r};
  endfunction

  always_comb {AluZero, AluOut} = alu_fn(AluOp, AluInputA, AluAccIn);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted command expands into a plan: one step per pass, then a Done step.
  typedef struct {
    logic       is_exec;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] acc_after;
    logic       z_after;
  } step_t;

  step_t      plan_q[$];
  logic [7:0] m_acc = 8'd0;
  logic       m_zero = 1'b0;
  logic [7:0] m_run;
  logic [8:0] m_res;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      plan_q.delete();
      m_acc  = 8'd0;
      m_zero = 1'b0;
    end else if (plan_q.size() == 0) begin
      if (CmdValid) begin
        m_run = m_acc;
        for (int i = 0; i <= int'(CmdRepeat); i++) begin
          m_res = alu_fn(CmdOp, CmdOperand, m_run);
          plan_q.push_back('{is_exec: 1'b1, op: CmdOp, a: CmdOperand,
                             acc_after: m_res[7:0], z_after: m_res[8]});
          m_run = m_res[7:0];
        end
        plan_q.push_back('{is_exec: 1'b0, op: kNOP, a: 8'd0, acc_after: 8'd0, z_after: 1'b0});
      end
    end else if (plan_q[0].is_exec) begin
      if (Abort) begin
        plan_q.delete();
      end else begin
        m_acc  = plan_q[0].acc_after;
        m_zero = plan_q[0].z_after;
        void'(plan_q.pop_front());
      end
    end else begin
      void'(plan_q.pop_front());
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge Clk) begin
    logic       e_ready, e_busy, e_done;
    logic [3:0] e_op;
    logic [7:0] e_a;
    if (plan_q.size() == 0) begin
      e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_op = kNOP; e_a = 8'd0;
    end else if (plan_q[0].is_exec) begin
      e_ready = 1'b0; e_busy = 1'b1; e_done = 1'b0; e_op = plan_q[0].op; e_a = plan_q[0].a;
    end else begin
      e_ready = 1'b0; e_busy = 1'b1; e_done = 1'b1; e_op = kNOP; e_a = 8'd0;
    end
    check("cmd_ready", int'(CmdReady), int'(e_ready));
    check("busy", int'(Busy), int'(e_busy));
    check("done", int'(Done), int'(e_done));
    check("alu_op", int'(AluOp), int'(e_op));
    check("alu_input_a", int'(AluInputA), int'(e_a));
    check("alu_acc_in", int'(AluAccIn), int'(m_acc));
    check("acc", int'(Acc), int'(m_acc));
    check("zero_flag", int'(ZeroFlag), int'(m_zero));
  end

  // ---------------- driver ----------------
  logic [7:0] acc_hist[$];

  // Called at a negedge with the DUT idle; returns at the negedge it is idle again.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] operand,
                         input int rpt, input int abort_at,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output int ready_after);
    bit idle_seen = 0;
    CmdValid   = 1'b1;
    CmdOp      = op;
    CmdOperand = operand;
    CmdRepeat  = RPT_W'(rpt);
    lat = 0; busy_cnt = 0; done_cnt = 0; ready_after = 0;
    acc_hist.delete();
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      CmdValid = 1'b0;
      Abort    = (k == abort_at);
      acc_hist.push_back(Acc);
      if (Busy) busy_cnt++;
      if (Done) begin done_cnt++; lat = k; end
      if (!Busy) begin
        ready_after = int'(CmdReady);
        idle_seen   = 1;
        break;
      end
    end
    Abort = 1'b0;
    if (!idle_seen) check("cmd_timeout", 0, 1);
  endtask

  int lat, bc, dc, ra, accepts, dones, rdy_busy;

  initial begin
    #1 Reset = 1'b1;
    #2;
    check("rst_acc", int'(Acc), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_ready", int'(CmdReady), 1);
    check("rst_done", int'(Done), 0);
    check("rst_zero", int'(ZeroFlag), 0);
    check("rst_aluop", int'(AluOp), int'(kNOP));
    @(negedge Clk);
    Reset = 1'b0;

    // First accept on the first edge after reset release; ADD 5 x3
    run_cmd(kADD, 8'd5, 2, 0, lat, bc, dc, ra);
    check("add_acc", int'(Acc), 15);
    check("add_model_acc", int'(m_acc), 15);
    check("add_latency", lat, 4);
    check("add_dones", dc, 1);
    check("add_zero", int'(ZeroFlag), 0);

    run_cmd(kSUB, 8'd15, 0, 0, lat, bc, dc, ra);
    check("sub_acc", int'(Acc), 0);
    check("sub_zero", int'(ZeroFlag), 1);
    check("sub_latency", lat, 2);

    run_cmd(kCLR, 8'd0, 0, 0, lat, bc, dc, ra);
    run_cmd(kADD, 8'd1, 0, 0, lat, bc, dc, ra);
    check("pre_lsl_acc", int'(Acc), 1);

    // Maximum repeat: 8 passes, 1 -> 2,4,...,128,0
    run_cmd(kLSL, 8'd1, 7, 0, lat, bc, dc, ra);
    for (int k = 2; k <= 9; k++) check("lsl_pass", int'(acc_hist[k-1]), (1 << (k-1)) & 255);
    check("lsl_acc", int'(Acc), 0);
    check("lsl_zero", int'(ZeroFlag), 1);
    check("lsl_busy_cycles", bc, 9);
    check("lsl_latency", lat, 9);

    // Abort on the 2nd EXEC cycle: only the first pass lands
    run_cmd(kADD, 8'd1, 3, 2, lat, bc, dc, ra);
    check("abort_acc", int'(Acc), 1);
    check("abort_dones", dc, 0);
    check("abort_ready_after", ra, 1);
    check("abort_busy_cycles", bc, 2);

    // CmdValid held high: accepts only in IDLE, one Done per accept
    CmdValid = 1'b1; CmdOp = kADD; CmdOperand = 8'd3; CmdRepeat = RPT_W'(1);
    accepts = int'(CmdReady); dones = 0; rdy_busy = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (k >= 8) CmdValid = 1'b0;
      if (CmdValid && CmdReady) accepts++;
      if (Done) dones++;
      if (Busy && CmdReady) rdy_busy++;
    end
    check("hold_accepts", accepts, 2);
    check("hold_dones", dones, 2);
    check("hold_ready_while_busy", rdy_busy, 0);
    check("hold_acc", int'(Acc), 13);

    // Reset mid-EXEC with Acc=200
    run_cmd(kCLR, 8'd0, 0, 0, lat, bc, dc, ra);
    CmdValid = 1'b1; CmdOp = kADD; CmdOperand = 8'd50; CmdRepeat = RPT_W'(7);
    @(negedge Clk);
    CmdValid = 1'b0;
    repeat (4) @(negedge Clk);
    check("pre_reset_acc", int'(Acc), 200);
    check("pre_reset_busy", int'(Busy), 1);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_acc", int'(Acc), 0);
    check("async_rst_busy", int'(Busy), 0);
    check("async_rst_ready", int'(CmdReady), 1);
    @(posedge Clk);
    #2 Reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    check("post_reset_dones", dones, 0);
    run_cmd(kADD, 8'd7, 1, 0, lat, bc, dc, ra);
    check("post_reset_acc", int'(Acc), 14);
    check("post_reset_latency", lat, 3);

    // Randomized traffic: gaps, all repeat counts, aborts, stray opcodes, resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      CmdValid   = ($urandom_range(0, 3) != 0);
      CmdOp      = 4'($urandom_range(0, 9));
      CmdOperand = 8'($urandom);
      CmdRepeat  = RPT_W'($urandom_range(0, (1 << RPT_W) - 1));
      Abort      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 Reset = 1'b1;
        @(posedge Clk);
        #2 Reset = 1'b0;
      end
    end
    @(negedge Clk);
    CmdValid = 1'b0;
    Abort    = 1'b0;
    repeat (12) @(negedge Clk);
    check("final_idle", int'(Busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 The block SHALL have parameter RPT_W, default 3, giving the repeat-count field width.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port CmdValid, input, 1, meaning a command is presented.
REQ-005 The block SHALL have port CmdReady, output, 1, meaning the block accepts a command this cycle.
REQ-006 The block SHALL have port CmdOp, input, 4, the ALU opcode, encoded per the definitions package (kADD, kSUB, kAND, kXOR, kRXR, kLSL, kCMP, kCLR).
REQ-007 The block SHALL have port CmdOperand, input, 8, the operand driven to the ALU InputA.
REQ-008 The block SHALL have port CmdRepeat, input, RPT_W, where the op executes CmdRepeat+1 times.
REQ-009 The block SHALL have port Abort, input, 1, which cancels the command in flight.
REQ-010 The block SHALL have port AluInputA, output, 8, driven to ALU InputA.
REQ-011 The block SHALL have port AluAccIn, output, 8, driven to ALU AccumulatorIn.
REQ-012 The block SHALL have port AluOp, output, 4, driven to ALU OP.
REQ-013 The block SHALL have port AluOut, input, 8, the ALU result.
REQ-014 The block SHALL have port AluZero, input, 1, the ALU zero flag.
REQ-015 The block SHALL have port Acc, output, 8, the accumulator register value.
REQ-016 The block SHALL have port ZeroFlag, output, 1, registered AluZero from the last committed pass.
REQ-017 The block SHALL have port Busy, output, 1, high in any state other than IDLE.
REQ-018 The block SHALL have port Done, output, 1, a one-cycle completion pulse.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, EXEC, and DONE.
REQ-020 In IDLE the block SHALL hold CmdReady=1, and a handshake SHALL occur when CmdValid&&CmdReady.
REQ-021 On handshake the block SHALL latch op, operand, and Remaining=CmdRepeat, and SHALL move to EXEC.
REQ-022 In any state other than IDLE the block SHALL hold CmdReady=0, and CmdValid SHALL be ignored.
REQ-023 In EXEC the block SHALL drive AluOp=latched op, AluInputA=latched operand, and AluAccIn=Acc, all combinationally from registers.
REQ-024 On each EXEC cycle without Abort, the block SHALL load AluOut into Acc and AluZero into ZeroFlag.
REQ-025 On each such cycle, if Remaining!=0 the block SHALL decrement Remaining and stay in EXEC; otherwise it SHALL go to DONE.
REQ-026 In DONE the block SHALL assert Done=1 for exactly one cycle and SHALL return to IDLE.
REQ-027 Latency from the handshake edge to Done high SHALL be CmdRepeat+2 cycles.
REQ-028 Back-to-back commands SHALL be possible with a single IDLE cycle between Done and the next accept.
REQ-029 Abort in EXEC SHALL suppress that cycle's Acc/ZeroFlag write, return to IDLE the next cycle, and produce no Done pulse.
REQ-030 Abort coinciding with the final EXEC pass SHALL win: no write, no Done.
REQ-031 Abort in IDLE or DONE SHALL have no effect, and DONE SHALL still pulse.
REQ-032 In IDLE and DONE the block SHALL drive AluOp to a value outside the defined opcodes (no-op, ALU passes the accumulator), AluInputA=0, and AluAccIn=Acc.
REQ-033 Acc arithmetic SHALL be 8-bit modulo 2^8 as produced by the ALU, and the block SHALL apply no saturation.
REQ-034 Remaining SHALL never underflow; CmdRepeat at its maximum (2^RPT_W-1) SHALL execute exactly 2^RPT_W passes.
REQ-035 Acc SHALL persist across commands, and only Reset, a kCLR pass, or ALU results SHALL change it.

Reset
REQ-036 Reset high SHALL immediately force state IDLE, Acc=0, ZeroFlag=0, Remaining=0, Done=0, Busy=0, CmdReady=1, and the latched op=no-op.
REQ-037 Reset asserted mid-EXEC SHALL discard the command, and no Done SHALL follow reset release.
REQ-038 The first handshake SHALL be possible on the first rising edge after Reset deasserts.

Verification
REQ-039 The bench SHALL check: Acc=0, then kADD, operand 5, repeat 2 -> three EXEC passes, Acc=15, Done high 4 cycles after accept, ZeroFlag=0.
REQ-040 The bench SHALL check: Acc=15, then kSUB, operand 15, repeat 0 -> Acc=0, ZeroFlag=1, Done after 2 cycles.
REQ-041 The bench SHALL check: Acc=1, then kLSL, operand 1, repeat 7 -> passes give 2,4,...,128,0, final Acc=0, ZeroFlag=1, and Busy high for 9 cycles.
REQ-042 The bench SHALL check: kADD, operand 1, repeat 3 with Abort on the 2nd EXEC cycle -> Acc=old+1, no Done, CmdReady=1 the cycle after.
REQ-043 The bench SHALL check: CmdValid held high during EXEC -> no second accept until IDLE, and exactly one Done per accepted command.
REQ-044 The bench SHALL check: Reset pulsed mid-EXEC (Acc=200) -> Acc=0, IDLE asynchronously, no Done; the next command executes normally.
